// File: rtl/c2f_chunk_reader_if.sv
// RAM read port plus outgoing 64-bit word stream of the C2F chunk reader.
// Stream handshake: a word transfers on a clock edge where valid and ready are both high; once valid rises, data holds steady and valid stays high until that transfer.
interface c2f_chunk_reader_if #(
  parameter int IDX_NBITS = 2,
  parameter int OFF_NBITS = 3
);
  logic [IDX_NBITS+OFF_NBITS-1:0] ramAddr;
  logic [63:0]                    ramData;
  logic [63:0]                    data;
  logic                           valid;
  logic                           ready;

  modport master (
    output ramAddr,
    input  ramData,
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  ramAddr,
    output ramData,
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/c2f_chunk_reader.sv
// Reads committed C2F chunks out of the burst RAM in ring order and streams them downstream.
// It counts held chunks so the CPU knows when a chunk slot is free again.
module c2f_chunk_reader #(
  parameter int IDX_NBITS = 2,
  parameter int OFF_NBITS = 3
) (
  input  logic                 pcieClk_in,
  input  logic                 reset_in,
  input  logic                 flush_in,
  input  logic                 commit_in,
  c2f_chunk_reader_if.master   bus,
  output logic                 chunkDone_out,
  output logic [IDX_NBITS:0]   heldCount_out,
  output logic                 overflow_out
);
  localparam int ADDR_NBITS = IDX_NBITS + OFF_NBITS;
  localparam int CNT_NBITS  = IDX_NBITS + 1;
  localparam logic [CNT_NBITS-1:0] NUM_CHUNKS = CNT_NBITS'(2 ** IDX_NBITS);

  logic [CNT_NBITS-1:0]  availCnt, availNext;
  logic [CNT_NBITS-1:0]  heldCnt, heldNext;
  logic                  overflow, overflowNext;
  logic [ADDR_NBITS-1:0] rdAddr;
  logic                  inflight, inflightLast;

  logic [63:0]           fifoData [0:1];
  logic [1:0]            fifoLast;
  logic                  head;
  logic [1:0]            occ, occNext;

  logic                  pop, push, issue, issueLast, commitAcc, chunkDone;
  logic                  tail;
  logic [2:0]            projOcc;

  always_comb begin
    pop       = (occ != 2'd0) && bus.ready;
    push      = inflight;
    // Occupancy after this cycle's pop and the in-flight word land; a new read is only safe below 2.
    projOcc   = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    issue     = (availCnt != '0) && (projOcc < 3'd2);
    issueLast = &rdAddr[OFF_NBITS-1:0];
    commitAcc = commit_in && (heldCnt < NUM_CHUNKS);
    chunkDone = pop && fifoLast[head];
    tail      = head ^ occ[0];

    availNext = availCnt;
    if (commitAcc && !(issue && issueLast)) begin
      availNext = availCnt + 1'b1;
    end else if (!commitAcc && issue && issueLast) begin
      availNext = availCnt - 1'b1;
    end

    heldNext = heldCnt;
    if (commitAcc && !chunkDone) begin
      heldNext = heldCnt + 1'b1;
    end else if (!commitAcc && chunkDone) begin
      heldNext = heldCnt - 1'b1;
    end

    overflowNext = overflow || (commit_in && !commitAcc);

    occNext = occ;
    if (push && !pop) begin
      occNext = occ + 2'd1;
    end else if (!push && pop) begin
      occNext = occ - 2'd1;
    end
  end

  always_ff @(posedge pcieClk_in or posedge reset_in) begin
    if (reset_in) begin
      availCnt     <= '0;
      heldCnt      <= '0;
      overflow     <= 1'b0;
      rdAddr       <= '0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
      fifoData[0]  <= '0;
      fifoData[1]  <= '0;
      fifoLast     <= '0;
      head         <= 1'b0;
      occ          <= '0;
    end else if (flush_in) begin
      // Flush wins over a coincident commit and drops any read still in flight.
      availCnt     <= '0;
      heldCnt      <= '0;
      overflow     <= 1'b0;
      rdAddr       <= '0;
      inflight     <= 1'b0;
      inflightLast <= 1'b0;
      fifoData[0]  <= '0;
      fifoData[1]  <= '0;
      fifoLast     <= '0;
      head         <= 1'b0;
      occ          <= '0;
    end else begin
      availCnt     <= availNext;
      heldCnt      <= heldNext;
      overflow     <= overflowNext;
      inflight     <= issue;
      inflightLast <= issue && issueLast;
      if (issue) begin
        rdAddr <= rdAddr + 1'b1;
      end
      if (push) begin
        fifoData[tail] <= bus.ramData;
        fifoLast[tail] <= inflightLast;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occNext;
    end
  end

  assign bus.ramAddr    = rdAddr;
  assign bus.data       = fifoData[head];
  assign bus.valid      = (occ != 2'd0);
  assign chunkDone_out  = chunkDone;
  assign heldCount_out  = heldCnt;
  assign overflow_out   = overflow;
endmodule

// File: tb/tb_c2f_chunk_reader.sv
// Bench for c2f_chunk_reader: a chunk-level model fed by commits predicts the delivered word stream.
// Directed scenarios add hand-computed cycle-exact expectations.
module tb_c2f_chunk_reader;
  localparam int IDX = 2;
  localparam int OFF = 3;
  localparam int NWORDS = 1 << (IDX + OFF);
  localparam int CHUNK_WORDS = 1 << OFF;
  localparam int NCHUNKS = 1 << IDX;

  logic           pcieClk_in;
  logic           reset_in;
  logic           flush_in;
  logic           commit_in;
  logic           chunkDone_out;
  logic [IDX:0]   heldCount_out;
  logic           overflow_out;

  c2f_chunk_reader_if #(.IDX_NBITS(IDX), .OFF_NBITS(OFF)) bus ();

  c2f_chunk_reader #(.IDX_NBITS(IDX), .OFF_NBITS(OFF)) dut (
    .pcieClk_in    (pcieClk_in),
    .reset_in      (reset_in),
    .flush_in      (flush_in),
    .commit_in     (commit_in),
    .bus           (bus),
    .chunkDone_out (chunkDone_out),
    .heldCount_out (heldCount_out),
    .overflow_out  (overflow_out)
  );

  // clock / reset
  initial pcieClk_in = 1'b0;
  always #4 pcieClk_in = ~pcieClk_in;

  // synchronous-read RAM preloaded with word i = 0x1000 + i
  logic [63:0] ram [0:NWORDS-1];
  initial begin
    for (int i = 0; i < NWORDS; i++) ram[i] = 64'h1000 + 64'(i);
  end
  always @(posedge pcieClk_in) bus.ramData <= ram[bus.ramAddr];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: expected words as {last, data}, plus chunk bookkeeping
  logic [64:0] exp_q[$];
  int          held_m;
  bit          ovf_m;
  int          next_chunk;
  int          occ_m;
  logic [IDX+OFF-1:0] prev_addr;
  bit          prev_valid, prev_ready;
  logic [63:0] prev_data;

  function automatic void model_clear();
    exp_q.delete();
    held_m     = 0;
    ovf_m      = 1'b0;
    next_chunk = 0;
    occ_m      = 0;
    prev_addr  = '0;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    prev_data  = '0;
  endfunction

  initial model_clear();

  always @(negedge pcieClk_in) begin
    logic [64:0] e;
    bit pop_m;
    bit addr_chg;
    if (reset_in) begin
      model_clear();
    end else begin
      check("held count", 64'(heldCount_out), 64'(held_m));
      check("overflow", 64'(overflow_out), 64'(ovf_m));
      check("valid vs occupancy", 64'(bus.valid), 64'(occ_m != 0));
      check("occupancy <= 2", 64'(occ_m <= 2), 64'd1);
      if (prev_valid && !prev_ready) begin
        check("stall valid held", 64'(bus.valid), 64'd1);
        check("stall data stable", bus.data, prev_data);
      end
      pop_m = bus.valid && bus.ready;
      e = '0;
      if (pop_m) begin
        if (exp_q.size() == 0) begin
          check("unexpected word", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream data", bus.data, e[63:0]);
          check("chunk done on pop", 64'(chunkDone_out), 64'(e[64]));
        end
      end else begin
        check("chunk done idle", 64'(chunkDone_out), 64'd0);
      end
      // an address step means a read was issued last cycle; its word lands at the end of this one
      addr_chg = (bus.ramAddr != prev_addr);
      occ_m = occ_m + (addr_chg ? 1 : 0) - (pop_m ? 1 : 0);
      prev_addr  = bus.ramAddr;
      prev_valid = bus.valid;
      prev_ready = bus.ready;
      prev_data  = bus.data;
      if (flush_in) begin
        model_clear();
      end else begin
        if (commit_in) begin
          if (held_m < NCHUNKS) begin
            held_m++;
            for (int w = 0; w < CHUNK_WORDS; w++)
              exp_q.push_back({w == CHUNK_WORDS - 1, ram[next_chunk * CHUNK_WORDS + w]});
            next_chunk = (next_chunk + 1) % NCHUNKS;
          end else begin
            ovf_m = 1'b1;
          end
        end
        if (pop_m && e[64]) held_m--;
      end
    end
  end

  // driver tasks
  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || bus.valid) && n < budget) begin
      @(negedge pcieClk_in);
      n++;
    end
    check(name, 64'(exp_q.size() == 0 && !bus.valid), 64'd1);
  endtask

  // one commit in cycle N with ready high; expects the chunk at base_addr delivered on N+3..N+10
  task automatic single_chunk(input string tag, input int base_addr);
    @(posedge pcieClk_in); #1 commit_in = 1'b1;
    @(negedge pcieClk_in);
    check({tag, " N valid"}, 64'(bus.valid), 64'd0);
    check({tag, " N held"}, 64'(heldCount_out), 64'd0);
    @(posedge pcieClk_in); #1 commit_in = 1'b0;
    @(negedge pcieClk_in);
    check({tag, " N+1 addr"}, 64'(bus.ramAddr), 64'(base_addr));
    check({tag, " N+1 held"}, 64'(heldCount_out), 64'd1);
    @(negedge pcieClk_in);
    check({tag, " N+2 addr"}, 64'(bus.ramAddr), 64'(base_addr + 1));
    check({tag, " N+2 valid"}, 64'(bus.valid), 64'd0);
    for (int k = 0; k < CHUNK_WORDS; k++) begin
      @(negedge pcieClk_in);
      check({tag, " word valid"}, 64'(bus.valid), 64'd1);
      check({tag, " word data"}, bus.data, 64'h1000 + 64'(base_addr + k));
      check({tag, " word done"}, 64'(chunkDone_out), 64'(k == CHUNK_WORDS - 1));
    end
    @(negedge pcieClk_in);
    check({tag, " N+11 held"}, 64'(heldCount_out), 64'd0);
    check({tag, " N+11 valid"}, 64'(bus.valid), 64'd0);
    check({tag, " N+11 addr"}, 64'(bus.ramAddr), 64'((base_addr + CHUNK_WORDS) % NWORDS));
  endtask

  initial begin
    #1000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int done_cnt;
    int c;
    reset_in  = 1'b1;
    flush_in  = 1'b0;
    commit_in = 1'b0;
    bus.ready = 1'b0;
    repeat (3) @(posedge pcieClk_in);
    #1 reset_in = 1'b0;
    @(negedge pcieClk_in);
    check("reset valid", 64'(bus.valid), 64'd0);
    check("reset data", bus.data, 64'd0);
    check("reset addr", 64'(bus.ramAddr), 64'd0);
    check("reset held", 64'(heldCount_out), 64'd0);
    check("reset overflow", 64'(overflow_out), 64'd0);
    repeat (5) @(posedge pcieClk_in);
    #1 bus.ready = 1'b1;

    // single chunk, exact latency
    single_chunk("t1", 0);

    // five back-to-back commits: four fill the ring, the fifth overflows
    for (c = 0; c < 40; c++) begin
      @(posedge pcieClk_in); #1 commit_in = (c < 5);
      @(negedge pcieClk_in);
      if (c >= 3 && c < 35) begin
        check("t2 no bubble", 64'(bus.valid), 64'd1);
        check("t2 done cadence", 64'(chunkDone_out), 64'(((c - 3) % 8) == 7));
      end
      if (c == 5) begin
        check("t2 held peak", 64'(heldCount_out), 64'd4);
        check("t2 overflow set", 64'(overflow_out), 64'd1);
      end
      if (c == 24) check("t2 addr 31", 64'(bus.ramAddr), 64'd31);
      if (c == 25) check("t2 addr wrap", 64'(bus.ramAddr), 64'd0);
    end
    check("t2 overflow sticky", 64'(overflow_out), 64'd1);
    @(posedge pcieClk_in); #1 flush_in = 1'b1;
    @(posedge pcieClk_in); #1 flush_in = 1'b0;
    @(negedge pcieClk_in);
    check("flush overflow clr", 64'(overflow_out), 64'd0);
    check("flush addr clr", 64'(bus.ramAddr), 64'd0);

    // random backpressure over three chunks
    done_cnt = 0;
    c = 0;
    while (c < 400 && (c < 4 || exp_q.size() != 0 || bus.valid)) begin
      @(posedge pcieClk_in);
      #1 commit_in = (c < 3);
      bus.ready = 1'($urandom_range(0, 1));
      @(negedge pcieClk_in);
      if (chunkDone_out) done_cnt++;
      c++;
    end
    check("t3 drained", 64'(exp_q.size()), 64'd0);
    check("t3 done pulses", 64'(done_cnt), 64'd3);
    @(posedge pcieClk_in); #1 bus.ready = 1'b1;
    @(negedge pcieClk_in);

    // commit coinciding with chunkDone while two chunks are held
    for (c = 0; c < 13; c++) begin
      @(posedge pcieClk_in); #1 commit_in = (c < 2) || (c == 10);
      @(negedge pcieClk_in);
      if (c == 2) check("t4 held 2", 64'(heldCount_out), 64'd2);
      if (c == 10) check("t4 done", 64'(chunkDone_out), 64'd1);
      if (c == 11) begin
        check("t4 held stays", 64'(heldCount_out), 64'd2);
        check("t4 no overflow", 64'(overflow_out), 64'd0);
      end
    end
    wait_drain("t4 drained", 100);

    // async reset while word 3 of chunk 1 is on the stream
    @(posedge pcieClk_in); #1 flush_in = 1'b1;
    @(posedge pcieClk_in); #1 flush_in = 1'b0;
    for (c = 0; c < 15; c++) begin
      @(posedge pcieClk_in); #1 commit_in = (c < 2);
      @(negedge pcieClk_in);
    end
    check("t5 word before reset", bus.data, 64'h100B);
    #1 reset_in = 1'b1;
    #1;
    check("t5 rst valid", 64'(bus.valid), 64'd0);
    check("t5 rst data", bus.data, 64'd0);
    check("t5 rst done", 64'(chunkDone_out), 64'd0);
    check("t5 rst held", 64'(heldCount_out), 64'd0);
    check("t5 rst overflow", 64'(overflow_out), 64'd0);
    check("t5 rst addr", 64'(bus.ramAddr), 64'd0);
    repeat (2) @(posedge pcieClk_in);
    #1 reset_in = 1'b0;
    single_chunk("t5", 0);

    // flush coincident with commit while a word is waiting
    @(posedge pcieClk_in); #1 bus.ready = 1'b0; commit_in = 1'b1;
    @(posedge pcieClk_in); #1 commit_in = 1'b0;
    c = 0;
    while (!bus.valid && c < 20) begin
      @(negedge pcieClk_in);
      c++;
    end
    check("t6 valid before flush", 64'(bus.valid), 64'd1);
    @(posedge pcieClk_in); #1 flush_in = 1'b1; commit_in = 1'b1;
    @(posedge pcieClk_in); #1 flush_in = 1'b0; commit_in = 1'b0;
    @(negedge pcieClk_in);
    check("t6 valid cleared", 64'(bus.valid), 64'd0);
    check("t6 held cleared", 64'(heldCount_out), 64'd0);
    repeat (3) @(negedge pcieClk_in);
    check("t6 commit lost held", 64'(heldCount_out), 64'd0);
    check("t6 no read issued", 64'(bus.ramAddr), 64'd0);
    check("t6 still idle", 64'(bus.valid), 64'd0);
    @(posedge pcieClk_in); #1 bus.ready = 1'b1;
    repeat (3) @(negedge pcieClk_in);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
